// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback-stage data types
package wb_pkg;

  typedef logic [31:0] reg_data_t;

  typedef struct packed {
    logic       rd_we;
    logic [4:0] rd;
  } decode_t;

  typedef struct packed {
    logic      valid;
    reg_data_t code;
    reg_data_t tval;
  } except_t;

  typedef struct packed {
    logic      valid;
    reg_data_t pc;
    decode_t   decode;
    except_t   except;
  } issued_instr_t;

endpackage

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - writeback stage: register commit, instret, trap/flush sequencing
module wb_unit
    import wb_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned INSTRET_W    = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  issued_instr_t        i_instr,
    input  reg_data_t            i_data,
    input  reg_data_t            i_trap_vec,
    input  logic                 i_instret_we,
    input  logic [INSTRET_W-1:0] i_instret_wdata,
    input  logic [31:0]          i_log_fd,
    output logic                 o_rd_wen,
    output logic [4:0]           o_rd_idx,
    output reg_data_t            o_rd_data,
    output logic                 o_flush,
    output logic                 o_redirect_valid,
    output reg_data_t            o_redirect_pc,
    output logic                 o_trap_valid,
    output reg_data_t            o_trap_epc,
    output reg_data_t            o_trap_cause,
    output reg_data_t            o_trap_tval,
    output logic [INSTRET_W-1:0] o_instret
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_TRAP  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] drain_cnt, drain_cnt_nxt;
    logic       retire;
    logic       trap_start;

    assign retire     = (state == ST_RUN) && i_instr.valid && !i_instr.except.valid;
    assign trap_start = (state == ST_RUN) && i_instr.valid &&  i_instr.except.valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_RUN;
            drain_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            ST_RUN: begin
                if (trap_start) state_nxt = ST_TRAP;
            end
            ST_TRAP: begin
                drain_cnt_nxt = 4'(DRAIN_CYCLES);
                state_nxt     = ST_DRAIN;
            end
            ST_DRAIN: begin
                drain_cnt_nxt = drain_cnt - 4'd1;
                if (drain_cnt == 4'd1) state_nxt = ST_RUN;
            end
            default: begin
                state_nxt     = ST_RUN;
                drain_cnt_nxt = 4'd0;
            end
        endcase
    end

    assign o_trap_valid     = (state == ST_TRAP);
    assign o_redirect_valid = (state == ST_TRAP);
    assign o_redirect_pc    = (state == ST_TRAP) ? i_trap_vec : '0;
    assign o_flush          = (state != ST_RUN);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_wen     <= 1'b0;
            o_rd_idx     <= 5'd0;
            o_rd_data    <= '0;
            o_trap_epc   <= '0;
            o_trap_cause <= '0;
            o_trap_tval  <= '0;
            o_instret    <= '0;
        end else begin
            o_rd_wen <= 1'b0;
            if (retire) begin
                o_rd_wen  <= i_instr.decode.rd_we && (i_instr.decode.rd != 5'd0);
                o_rd_idx  <= i_instr.decode.rd;
                o_rd_data <= i_data;
            end
            if (trap_start) begin
                o_trap_epc   <= i_instr.pc;
                o_trap_cause <= i_instr.except.code;
                o_trap_tval  <= i_instr.except.tval;
            end
            if (i_instret_we)
                o_instret <= i_instret_wdata;
            else if (retire)
                o_instret <= o_instret + INSTRET_W'(1);
        end
    end

`ifndef SYNTHESIS
    always @(posedge i_clk) begin
        if (!i_rst && (i_log_fd != 32'd0) && i_instr.valid)
            $display("wb pc=%h exc=%b rd=%0d data=%h",
                     i_instr.pc, i_instr.except.valid, i_instr.decode.rd, i_data);
    end
`endif

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - directed self-checking bench for wb_unit
module tb_wb_unit;
  import wb_pkg::*;

  localparam int unsigned DRAIN_CYCLES = 2;
  localparam int unsigned INSTRET_W    = 64;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  issued_instr_t        i_instr;
  reg_data_t            i_data;
  reg_data_t            i_trap_vec;
  logic                 i_instret_we;
  logic [INSTRET_W-1:0] i_instret_wdata;
  logic [31:0]          i_log_fd;
  logic                 o_rd_wen;
  logic [4:0]           o_rd_idx;
  reg_data_t            o_rd_data;
  logic                 o_flush;
  logic                 o_redirect_valid;
  reg_data_t            o_redirect_pc;
  logic                 o_trap_valid;
  reg_data_t            o_trap_epc;
  reg_data_t            o_trap_cause;
  reg_data_t            o_trap_tval;
  logic [INSTRET_W-1:0] o_instret;

  int n_checks = 0;
  int n_fail   = 0;

  wb_unit #(.DRAIN_CYCLES(DRAIN_CYCLES), .INSTRET_W(INSTRET_W)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_instr         (i_instr),
    .i_data          (i_data),
    .i_trap_vec      (i_trap_vec),
    .i_instret_we    (i_instret_we),
    .i_instret_wdata (i_instret_wdata),
    .i_log_fd        (i_log_fd),
    .o_rd_wen        (o_rd_wen),
    .o_rd_idx        (o_rd_idx),
    .o_rd_data       (o_rd_data),
    .o_flush         (o_flush),
    .o_redirect_valid(o_redirect_valid),
    .o_redirect_pc   (o_redirect_pc),
    .o_trap_valid    (o_trap_valid),
    .o_trap_epc      (o_trap_epc),
    .o_trap_cause    (o_trap_cause),
    .o_trap_tval     (o_trap_tval),
    .o_instret       (o_instret)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_idle();
    i_instr = '0;
    i_data  = '0;
  endtask

  task automatic drive_retire(input reg_data_t pc, input logic we, input logic [4:0] rd, input reg_data_t data);
    i_instr              = '0;
    i_instr.valid        = 1'b1;
    i_instr.pc           = pc;
    i_instr.decode.rd_we = we;
    i_instr.decode.rd    = rd;
    i_data               = data;
  endtask

  task automatic drive_except(input reg_data_t pc, input reg_data_t code, input reg_data_t tval);
    i_instr              = '0;
    i_instr.valid        = 1'b1;
    i_instr.pc           = pc;
    i_instr.decode.rd_we = 1'b1;
    i_instr.decode.rd    = 5'd9;
    i_instr.except.valid = 1'b1;
    i_instr.except.code  = code;
    i_instr.except.tval  = tval;
    i_data               = 32'h1111_2222;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    drive_idle();
    cyc(); cyc();
    n_checks++; if (o_rd_wen !== 1'b0) begin n_fail++; $display("FAIL reset_rd_wen got %b want 0", o_rd_wen); end
    n_checks++; if (o_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", o_rd_data); end
    n_checks++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", o_flush); end
    n_checks++; if (o_trap_valid !== 1'b0 || o_redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got %b%b want 00", o_trap_valid, o_redirect_valid); end
    n_checks++; if (o_instret !== 64'h0) begin n_fail++; $display("FAIL reset_instret got %h want 0", o_instret); end
    n_checks++; if (o_trap_epc !== 32'h0 || o_redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_trap_fields got epc=%h rpc=%h want 0", o_trap_epc, o_redirect_pc); end
    i_rst = 1'b0;
  endtask

  task automatic test_retire_write();
    drive_retire(32'h100, 1'b1, 5'd5, 32'hDEAD_BEEF);
    cyc();
    n_checks++; if (o_rd_wen !== 1'b1) begin n_fail++; $display("FAIL retire_wen got %b want 1", o_rd_wen); end
    n_checks++; if (o_rd_idx !== 5'd5) begin n_fail++; $display("FAIL retire_idx got %0d want 5", o_rd_idx); end
    n_checks++; if (o_rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL retire_data got %h want deadbeef", o_rd_data); end
    n_checks++; if (o_instret !== 64'd1) begin n_fail++; $display("FAIL retire_instret got %0d want 1", o_instret); end
    drive_idle();
    cyc();
    n_checks++; if (o_rd_wen !== 1'b0) begin n_fail++; $display("FAIL retire_wen_pulse got %b want 0", o_rd_wen); end
  endtask

  task automatic test_x0_bubbles();
    drive_retire(32'h104, 1'b1, 5'd0, 32'h1234_5678);
    cyc();
    n_checks++; if (o_rd_wen !== 1'b0) begin n_fail++; $display("FAIL x0_wen got %b want 0", o_rd_wen); end
    n_checks++; if (o_instret !== 64'd2) begin n_fail++; $display("FAIL x0_instret got %0d want 2", o_instret); end
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (o_rd_wen !== 1'b0 || o_instret !== 64'd2) begin n_fail++; $display("FAIL bubble_%0d got wen=%b instret=%0d want wen=0 instret=2", i, o_rd_wen, o_instret); end
    end
  endtask

  task automatic test_trap();
    int flush_cnt;
    flush_cnt = 0;
    i_trap_vec = 32'h1000;
    drive_except(32'h200, 32'd13, 32'h8000_0010);
    cyc();
    // TRAP cycle; a second exception offered here must be discarded
    if (o_flush === 1'b1) flush_cnt++;
    n_checks++; if (o_trap_valid !== 1'b1 || o_redirect_valid !== 1'b1) begin n_fail++; $display("FAIL trap_pulses got %b%b want 11", o_trap_valid, o_redirect_valid); end
    n_checks++; if (o_redirect_pc !== 32'h1000) begin n_fail++; $display("FAIL trap_redirect_pc got %h want 1000", o_redirect_pc); end
    n_checks++; if (o_trap_epc !== 32'h200) begin n_fail++; $display("FAIL trap_epc got %h want 200", o_trap_epc); end
    n_checks++; if (o_trap_cause !== 32'd13) begin n_fail++; $display("FAIL trap_cause got %0d want 13", o_trap_cause); end
    n_checks++; if (o_trap_tval !== 32'h8000_0010) begin n_fail++; $display("FAIL trap_tval got %h want 80000010", o_trap_tval); end
    n_checks++; if (o_rd_wen !== 1'b0 || o_instret !== 64'd2) begin n_fail++; $display("FAIL trap_nocommit got wen=%b instret=%0d want 0/2", o_rd_wen, o_instret); end
    drive_except(32'h300, 32'd2, 32'hAAAA_0000);
    cyc();
    if (o_flush === 1'b1) flush_cnt++;
    n_checks++; if (o_trap_valid !== 1'b0 || o_redirect_valid !== 1'b0) begin n_fail++; $display("FAIL drain_pulses got %b%b want 00", o_trap_valid, o_redirect_valid); end
    drive_retire(32'h204, 1'b1, 5'd7, 32'h7777_7777);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (o_flush === 1'b1) flush_cnt++;
      n_checks++; if (o_rd_wen !== 1'b0 || o_instret !== 64'd2) begin n_fail++; $display("FAIL drain_ignore_%0d got wen=%b instret=%0d want 0/2", i, o_rd_wen, o_instret); end
      if (i == 0) drive_idle();
    end
    n_checks++; if (flush_cnt != 1 + DRAIN_CYCLES) begin n_fail++; $display("FAIL flush_window got %0d want %0d", flush_cnt, 1 + DRAIN_CYCLES); end
    n_checks++; if (o_trap_epc !== 32'h200 || o_trap_cause !== 32'd13) begin n_fail++; $display("FAIL trap_hold got epc=%h cause=%0d want 200/13", o_trap_epc, o_trap_cause); end
    drive_retire(32'h1000, 1'b1, 5'd3, 32'hCAFE_0001);
    cyc();
    n_checks++; if (o_rd_wen !== 1'b1 || o_rd_idx !== 5'd3 || o_instret !== 64'd3) begin n_fail++; $display("FAIL post_trap_retire got wen=%b idx=%0d instret=%0d want 1/3/3", o_rd_wen, o_rd_idx, o_instret); end
    drive_idle();
    cyc();
  endtask

  task automatic test_counter_wrap();
    i_instret_we    = 1'b1;
    i_instret_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    drive_retire(32'h1004, 1'b1, 5'd4, 32'h4);
    cyc();
    i_instret_we = 1'b0;
    n_checks++; if (o_instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL csr_write_wins got %h want ffffffffffffffff", o_instret); end
    drive_retire(32'h1008, 1'b1, 5'd4, 32'h8);
    cyc();
    n_checks++; if (o_instret !== 64'h0) begin n_fail++; $display("FAIL instret_wrap got %h want 0", o_instret); end
    drive_idle();
    cyc();
  endtask

  task automatic test_reset_mid_drain();
    i_trap_vec = 32'h2000;
    drive_except(32'h400, 32'd5, 32'h44);
    cyc();
    drive_idle();
    cyc();
    n_checks++; if (o_flush !== 1'b1) begin n_fail++; $display("FAIL pre_reset_drain got flush=%b want 1", o_flush); end
    i_rst = 1'b1;
    cyc();
    n_checks++; if (o_flush !== 1'b0 || o_trap_valid !== 1'b0 || o_redirect_valid !== 1'b0 || o_redirect_pc !== 32'h0) begin n_fail++; $display("FAIL mid_reset_ctrl got flush=%b tv=%b rv=%b rpc=%h want all 0", o_flush, o_trap_valid, o_redirect_valid, o_redirect_pc); end
    n_checks++; if (o_trap_epc !== 32'h0 || o_trap_cause !== 32'h0 || o_trap_tval !== 32'h0 || o_instret !== 64'h0) begin n_fail++; $display("FAIL mid_reset_fields got epc=%h cause=%h tval=%h instret=%h want 0", o_trap_epc, o_trap_cause, o_trap_tval, o_instret); end
    i_rst = 1'b0;
    drive_retire(32'h500, 1'b1, 5'd3, 32'h55);
    cyc();
    n_checks++; if (o_rd_wen !== 1'b1 || o_rd_data !== 32'h55 || o_instret !== 64'd1 || o_flush !== 1'b0) begin n_fail++; $display("FAIL post_reset_retire got wen=%b data=%h instret=%0d flush=%b want 1/55/1/0", o_rd_wen, o_rd_data, o_instret, o_flush); end
    drive_idle();
  endtask

  initial begin
    i_rst           = 1'b1;
    i_instr         = '0;
    i_data          = '0;
    i_trap_vec      = '0;
    i_instret_we    = 1'b0;
    i_instret_wdata = '0;
    i_log_fd        = 32'd0;
    test_reset();
    test_retire_write();
    test_x0_bubbles();
    test_trap();
    test_counter_wrap();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
